// File: rtl/branch_result_queue.sv
// branch_result_queue
//   Holds resolved branch/jump results (ROB tag + next PC) coming out of the
//   branch reservation station until the CDB arbiter grants a broadcast slot.
//   The upstream station never stalls, so results that cannot be stored are
//   dropped and recorded in sticky error flags.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   resultValid       one-cycle result strobe from the branch RS
//   resultRobNum      ROB tag of the resolved branch (16 = "no tag")
//   resultData        resolved next PC
//   full, count       occupancy (registered)
//   cdbRequest        head entry valid, asking for a CDB slot (registered)
//   cdbGrant          arbiter grant for this cycle
//   cdbIscast         one-cycle broadcast strobe
//   cdbRobNum/cdbData broadcast payload, held while cdbIscast is low
//   flush             mispredict recovery: discard everything queued
//   overflow          sticky: valid result dropped because the queue was full
//   badTag            sticky: result arrived with tag >= 16
module branch_result_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ROB_W  = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              resultValid,
    input  logic [ROB_W-1:0]  resultRobNum,
    input  logic [DATA_W-1:0] resultData,
    output logic              full,
    output logic [2:0]        count,
    output logic              cdbRequest,
    input  logic              cdbGrant,
    output logic              cdbIscast,
    output logic [ROB_W-1:0]  cdbRobNum,
    output logic [DATA_W-1:0] cdbData,
    input  logic              flush,
    output logic              overflow,
    output logic              badTag
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 3;
    localparam logic [ROB_W-1:0] NO_TAG = ROB_W'(16);

    typedef struct packed {
        logic [ROB_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic               tag_ok;
    logic               push;
    logic               pop;

    logic [PTR_W-1:0]   wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [CNT_W-1:0]   count_next;
    logic               full_next;
    logic               request_next;
    logic               iscast_next;
    logic [ROB_W-1:0]   rob_num_next;
    logic [DATA_W-1:0]  data_next;
    logic               overflow_next;
    logic               bad_tag_next;

    // Accept/pop decisions use registered state only; flush suppresses both.
    always_comb begin
        tag_ok = (resultRobNum < NO_TAG);
        push   = resultValid && !full && tag_ok && !flush;
        pop    = cdbRequest && cdbGrant && !flush;
    end

    // Next-state for pointers, occupancy, broadcast payload and sticky flags.
    always_comb begin
        wr_ptr_next   = wr_ptr;
        rd_ptr_next   = rd_ptr;
        count_next    = count;
        iscast_next   = 1'b0;
        rob_num_next  = cdbRobNum;
        data_next     = cdbData;
        overflow_next = overflow;
        bad_tag_next  = badTag;

        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next  = rd_ptr + PTR_W'(1);
                iscast_next  = 1'b1;
                rob_num_next = mem[rd_ptr].tag;
                data_next    = mem[rd_ptr].data;
            end
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
            // A bad tag wins over the full condition when both apply.
            if (resultValid && !tag_ok) begin
                bad_tag_next = 1'b1;
            end
            if (resultValid && tag_ok && full) begin
                overflow_next = 1'b1;
            end
        end

        full_next    = (count_next == CNT_W'(DEPTH));
        request_next = (count_next != CNT_W'(0));
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            cdbRequest <= 1'b0;
            cdbIscast  <= 1'b0;
            cdbRobNum  <= NO_TAG;
            cdbData    <= '0;
            overflow   <= 1'b0;
            badTag     <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            full       <= full_next;
            cdbRequest <= request_next;
            cdbIscast  <= iscast_next;
            cdbRobNum  <= rob_num_next;
            cdbData    <= data_next;
            overflow   <= overflow_next;
            badTag     <= bad_tag_next;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr] <= '{tag: resultRobNum, data: resultData};
        end
    end

endmodule

// File: tb/tb_branch_result_queue.sv
module tb_branch_result_queue;

    logic        clock;
    logic        reset;
    logic        resultValid;
    logic [5:0]  resultRobNum;
    logic [31:0] resultData;
    logic        full;
    logic [2:0]  count;
    logic        cdbRequest;
    logic        cdbGrant;
    logic        cdbIscast;
    logic [5:0]  cdbRobNum;
    logic [31:0] cdbData;
    logic        flush;
    logic        overflow;
    logic        badTag;

    branch_result_queue #(.DEPTH(4), .ROB_W(6), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .resultValid  (resultValid),
        .resultRobNum (resultRobNum),
        .resultData   (resultData),
        .full         (full),
        .count        (count),
        .cdbRequest   (cdbRequest),
        .cdbGrant     (cdbGrant),
        .cdbIscast    (cdbIscast),
        .cdbRobNum    (cdbRobNum),
        .cdbData      (cdbData),
        .flush        (flush),
        .overflow     (overflow),
        .badTag       (badTag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Expected broadcasts, {tag, data}, in order of acceptance.
    logic [37:0] sb [$];
    int   m_cnt   = 0;
    logic m_ovf   = 1'b0;
    logic m_bad   = 1'b0;
    logic exp_cast = 1'b0;
    logic mon_en  = 1'b0;

    // Broadcast monitor: strobe must match the expected pop, payload the scoreboard head.
    always @(negedge clock) begin
        if (mon_en) begin
            total++;
            if (cdbIscast !== exp_cast) begin
                bad++;
                $display("FAIL cast_strobe: got %b want %b at %0t", cdbIscast, exp_cast, $time);
            end
            if (exp_cast && cdbIscast === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL cast_unexpected: got tag %0d data %h, none expected", cdbRobNum, cdbData);
                end else begin
                    if ({cdbRobNum, cdbData} !== sb[0]) begin
                        bad++;
                        $display("FAIL cast_payload: got tag %0d data %h want tag %0d data %h",
                                 cdbRobNum, cdbData, sb[0][37:32], sb[0][31:0]);
                    end
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Drive one cycle of inputs and advance the reference model across the edge.
    task automatic step(input logic v, input logic [5:0] t, input logic [31:0] d,
                        input logic g, input logic f);
        logic acc;
        logic pp;
        int   pre;
        resultValid  = v;
        resultRobNum = t;
        resultData   = d;
        cdbGrant     = g;
        flush        = f;
        pre = m_cnt;
        acc = v && (pre != 4) && (t < 6'd16) && !f;
        pp  = (pre != 0) && g && !f;
        @(posedge clock);
        #1;
        if (f) begin
            m_cnt = 0;
            sb.delete();
        end else begin
            m_cnt = m_cnt + int'(acc) - int'(pp);
            if (acc) sb.push_back({t, d});
            if (v && t >= 6'd16) m_bad = 1'b1;
            if (v && t < 6'd16 && pre == 4) m_ovf = 1'b1;
        end
        exp_cast = pp;
    endtask

    task automatic idle(input logic g);
        step(1'b0, 6'd0, 32'd0, g, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        resultValid = 1'b0; cdbGrant = 1'b0; flush = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_cnt = 0; m_ovf = 1'b0; m_bad = 1'b0; exp_cast = 1'b0;
        sb.delete();
        mon_en = 1'b1;
    endtask

    // Grant until empty (bounded) and confirm every accepted result was broadcast.
    task automatic drain(input string name);
        int n = 0;
        while ((m_cnt != 0 || sb.size() != 0) && n < 20) begin
            idle(1'b1);
            n++;
        end
        idle(1'b0);
        total++;
        if (count !== 3'd0 || sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: count %0d pending %0d want 0 0", name, count, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        do_reset();
        total++;
        if ({full, count, cdbRequest, cdbIscast, cdbRobNum, cdbData, overflow, badTag}
            !== {1'b0, 3'd0, 1'b0, 1'b0, 6'd16, 32'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: full %b count %0d req %b cast %b tag %0d data %h ovf %b bad %b",
                     full, count, cdbRequest, cdbIscast, cdbRobNum, cdbData, overflow, badTag);
        end
    endtask

    task automatic test_single();
        step(1'b1, 6'd3, 32'h40, 1'b1, 1'b0);
        total++;
        if (cdbRequest !== 1'b1 || count !== 3'd1 || cdbIscast !== 1'b0) begin
            bad++;
            $display("FAIL single_request: req %b count %0d cast %b want 1 1 0", cdbRequest, count, cdbIscast);
        end
        idle(1'b1);
        total++;
        if (cdbIscast !== 1'b1 || cdbRobNum !== 6'd3 || cdbData !== 32'h40) begin
            bad++;
            $display("FAIL single_latency: cast %b tag %0d data %h want 1 3 40", cdbIscast, cdbRobNum, cdbData);
        end
        total++;
        if (count !== 3'd0 || cdbRequest !== 1'b0) begin
            bad++;
            $display("FAIL single_empty: count %0d req %b want 0 0", count, cdbRequest);
        end
        idle(1'b1);
        total++;
        if (cdbRobNum !== 6'd3 || cdbData !== 32'h40) begin
            bad++;
            $display("FAIL single_hold: tag %0d data %h want 3 40", cdbRobNum, cdbData);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 4; i++) step(1'b1, 6'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
        total++;
        if (full !== 1'b1 || count !== 3'd4) begin
            bad++;
            $display("FAIL fill_full: full %b count %0d want 1 4", full, count);
        end
        step(1'b1, 6'd5, 32'h555, 1'b0, 1'b0);
        total++;
        if (overflow !== 1'b1 || count !== 3'd4 || badTag !== 1'b0) begin
            bad++;
            $display("FAIL fill_overflow: ovf %b count %0d bad %b want 1 4 0", overflow, count, badTag);
        end
        drain("fill");
    endtask

    task automatic test_push_pop();
        step(1'b1, 6'd7, 32'h700, 1'b0, 1'b0);
        step(1'b1, 6'd8, 32'h800, 1'b1, 1'b0);
        total++;
        if (count !== 3'd1 || cdbRequest !== 1'b1) begin
            bad++;
            $display("FAIL pushpop_count: count %0d req %b want 1 1", count, cdbRequest);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 6'((9 + i) % 16), 32'h900 + 32'(i), 1'b1, 1'b0);
            total++;
            if (count !== 3'd1) begin
                bad++;
                $display("FAIL pushpop_wrap: count %0d want 1 (iter %0d)", count, i);
            end
        end
        drain("pushpop");
    endtask

    task automatic test_full_grant();
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 6'(i), 32'h200 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 6'd10, 32'hAAA, 1'b1, 1'b0);
        total++;
        if (count !== 3'd3 || overflow !== 1'b1 || full !== 1'b0) begin
            bad++;
            $display("FAIL fullgrant: count %0d ovf %b full %b want 3 1 0", count, overflow, full);
        end
        drain("fullgrant");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) step(1'b1, 6'(11 + i), 32'h300 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 6'd14, 32'hEEE, 1'b1, 1'b1);
        total++;
        if (count !== 3'd0 || cdbIscast !== 1'b0 || cdbRequest !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL flush_state: count %0d cast %b req %b ovf %b want 0 0 0 1",
                     count, cdbIscast, cdbRequest, overflow);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        total++;
        if (count !== 3'd0) begin
            bad++;
            $display("FAIL flush_after: count %0d want 0", count);
        end
    endtask

    task automatic test_bad_tag();
        step(1'b1, 6'd2, 32'h22, 1'b0, 1'b0);
        step(1'b1, 6'd16, 32'h16, 1'b0, 1'b0);
        total++;
        if (badTag !== 1'b1 || count !== 3'd1) begin
            bad++;
            $display("FAIL badtag_set: bad %b count %0d want 1 1", badTag, count);
        end
        step(1'b1, 6'd63, 32'h63, 1'b1, 1'b0);
        total++;
        if (badTag !== 1'b1 || count !== 3'd0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL badtag_hi: bad %b count %0d ovf %b want 1 0 1", badTag, count, overflow);
        end
        idle(1'b0);
        do_reset();
        total++;
        if (badTag !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL badtag_reset: bad %b ovf %b want 0 0", badTag, overflow);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            logic [5:0] t;
            t = ($urandom_range(0, 15) == 0) ? 6'(16 + $urandom_range(0, 47)) : 6'($urandom_range(0, 15));
            step(1'($urandom_range(0, 3) != 0), t, $urandom, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0));
            total++;
            if (count !== 3'(m_cnt) || full !== (m_cnt == 4) || cdbRequest !== (m_cnt != 0)
                || overflow !== m_ovf || badTag !== m_bad) begin
                bad++;
                $display("FAIL random_state: count %0d/%0d full %b req %b ovf %b/%b bad %b/%b (cycle %0d)",
                         count, m_cnt, full, cdbRequest, overflow, m_ovf, badTag, m_bad, i);
            end
        end
        drain("random");
    endtask

    initial begin
        reset = 1'b1; resultValid = 1'b0; resultRobNum = '0; resultData = '0;
        cdbGrant = 1'b0; flush = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_push_pop();
        test_full_grant();
        test_fill_overflow();
        test_flush();
        test_bad_tag();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
